key_encode83: RTL



---
 rtl/key_encode83_if.sv | 28 ++
 rtl/key_encode83.sv | 124 ++++++++++++
 2 files changed

// File: rtl/key_encode83_if.sv
// Key-to-encoder signal bundle: raw active-low keys in, registered code and strobes out.
// The master side is the board/driver; the slave side is the encoder.
interface key_encode83_if;
  logic [7:0] key;
  logic [2:0] code;
  logic       valid;
  logic       multi;
  logic       press_pulse;
  logic       release_pulse;

  modport master (
    output key,
    input  code,
    input  valid,
    input  multi,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key,
    output code,
    output valid,
    output multi,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_encode83.sv
// 8-to-3 key encoder: two-flop synchroniser, whole-vector debounce, priority encode,
// and a small FSM that emits registered press/release strobes. Code = 7 - key index.
module key_encode83 #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 20
) (
  input logic           clk,
  input logic           rst,
  key_encode83_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StHold, StRel} state_e;

  logic [7:0]       sync1_q, sync_q;
  logic [7:0]       smp_q, db_q;
  logic [CNT_W-1:0] cnt_q;

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       valid_q, multi_q;

  logic [2:0] enc;
  logic       any;
  logic       many;
  logic [3:0] nz;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'hFF;
      sync_q  <= 8'hFF;
    end else begin
      sync1_q <= bus.key;
      sync_q  <= sync1_q;
    end
  end

  // Any bit change restarts the window; the counter parks at CntMax rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q <= 8'hFF;
      cnt_q <= '0;
      db_q  <= 8'hFF;
    end else if (sync_q != smp_q) begin
      smp_q <= sync_q;
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      db_q <= smp_q;
    end
  end

  // Ascending scan so the highest pressed index (lowest code) is the last to win.
  always_comb begin
    enc = 3'd0;
    nz  = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!db_q[i]) begin
        enc = 3'(7 - i);
        nz  = nz + 4'd1;
      end
    end
    any  = (db_q != 8'hFF);
    many = (nz > 4'd1);
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d = StPress;
          code_d  = enc;
          press_d = 1'b1;
        end
      end
      StPress: state_d = StHold;
      StHold: begin
        if (!any) begin
          state_d   = StRel;
          release_d = 1'b1;
        end else if (enc != code_q) begin
          state_d = StPress;
          code_d  = enc;
          press_d = 1'b1;
        end
      end
      StRel:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      code_q    <= 3'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= any;
      multi_q   <= many;
    end
  end

  assign bus.code          = code_q;
  assign bus.valid         = valid_q;
  assign bus.multi         = multi_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

endmodule
